// File: rtl/gat_pkg.sv
// Shared types and width helpers for the GAT feature readout path.
package gat_pkg;

    // Readout frame sequencing.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Word-index width for a memory of the given depth (at least 1 bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold 0..fifo_depth, used for credits and FIFO occupancy.
    function automatic int unsigned credit_w(input int unsigned fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction

endpackage

// File: rtl/gat_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The writer is responsible for never writing when the FIFO is full.
module gat_sync_fifo
    import gat_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic [W-1:0]                 i_wr_data,
    input  logic                         i_rd_en,
    output logic [W-1:0]                 o_rd_data,
    output logic                         o_empty,
    output logic [credit_w(DEPTH)-1:0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_rd;

    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy; simultaneous write and read keep the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_wr_en, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gat_feat_reader.sv
// Walks the new-feature BRAM after gat_ready rises and streams every word
// out on a valid/ready interface; reads are credit-limited so the output
// FIFO can always absorb the data still in the BRAM read pipeline.
module gat_feat_reader
    import gat_pkg::*;
#(
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int READ_LATENCY      = 2,
    parameter int FIFO_DEPTH        = 4,
    localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    localparam int NEW_FEATURE_ADDR_W = addr_w(NEW_FEATURE_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            busy,
    output logic                            frame_done
);
    localparam int AW  = NEW_FEATURE_ADDR_W;
    localparam int CW  = credit_w(FIFO_DEPTH);
    localparam int FCW = addr_w(NUM_FEATURE_OUT);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_gat_prev;
    logic [AW+1:0]           r_addr;
    logic [CW-1:0]           r_outst;
    logic [READ_LATENCY-1:0] r_vld_pipe;
    logic [FCW-1:0]          r_feat_cnt;

    logic                    w_rise;
    logic                    w_issue;
    logic                    w_retire;
    logic                    w_pop;
    logic                    w_last_word;
    logic                    w_credit_ok;
    logic                    w_fifo_empty;
    logic [CW-1:0]           w_fifo_count;

    assign w_rise      = gat_ready && !r_gat_prev;
    assign w_retire    = r_vld_pipe[READ_LATENCY-1];
    assign w_last_word = (r_addr[AW+1:2] == AW'(NEW_FEATURE_DEPTH - 1));
    // Reads in flight plus words already buffered must leave a free slot.
    assign w_credit_ok = (({1'b0, r_outst} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign m_tvalid    = !w_fifo_empty;
    assign w_pop       = m_tvalid && m_tready;
    assign m_tlast     = m_tvalid && (r_feat_cnt == FCW'(NUM_FEATURE_OUT - 1));
    assign feat_bram_addrb = r_addr;

    gat_sync_fifo #(
        .W     (NEW_FEATURE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_retire),
        .i_wr_data (feat_bram_dout),
        .i_rd_en   (w_pop),
        .o_rd_data (m_tdata),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    // Next-state, read issue and status outputs. DRAIN leaves on the edge
    // that accepts the final beat so busy falls as frame_done rises.
    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_next = ST_READ;
            end
            ST_READ: begin
                busy    = 1'b1;
                w_issue = w_credit_ok;
                if (w_issue && w_last_word) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_outst == '0 &&
                    (w_fifo_empty || (w_fifo_count == CW'(1) && w_pop)))
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and gat_ready edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gat_prev <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_gat_prev <= gat_ready;
        end
    end

    // Byte address: advances one word per issue, rewinds when the frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_issue) begin
            r_addr <= r_addr + (AW+2)'(4);
        end else if (r_state == ST_DONE) begin
            r_addr <= '0;
        end
    end

    // Outstanding-read credit count and BRAM latency valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst    <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= (r_vld_pipe << 1) | READ_LATENCY'(w_issue);
            case ({w_issue, w_retire})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Feature-within-node counter driving m_tlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_feat_cnt <= '0;
        end else if (w_pop) begin
            if (r_feat_cnt == FCW'(NUM_FEATURE_OUT - 1)) r_feat_cnt <= '0;
            else                                          r_feat_cnt <= r_feat_cnt + 1'b1;
        end
    end

endmodule
